axi_read_arbiter: RTL and testbench

- Shares the single AXI read channel (AR/R) of the cache controller between two refill requesters: instruction-cache refill (port 0) and data-cache refill/uncached load (port 1).
- One outstanding read burst at a time, round-robin grant when both request, with R beats routed back to the granted requester.
- Sits between the cache controller's miss handlers and the top-level AXI AR/R pins.

---
 rtl/axi_read_arbiter.sv | 159 +++++++++++++++
 tb/tb_axi_read_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Shares the single AXI read channel (AR/R) between icache refill (port 0) and
// dcache refill/uncached load (port 1): one burst in flight, round-robin on ties.
module axi_read_arbiter #(
  parameter logic [3:0]  ID_I   = 4'd0,
  parameter logic [3:0]  ID_D   = 4'd1,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [3:0]        req_len0,
  input  logic [3:0]        req_len1,
  output logic [1:0]        req_ready,
  output logic [31:0]       resp_data,
  output logic [1:0]        resp_valid,
  output logic              resp_last,
  output logic              resp_err,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] SIZE_4B = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic              winner_c;
  logic              load_c;
  logic              burst_done_c;
  logic [1:0]        owner_onehot_c;
  logic [LEN_W-1:0]  win_len_c;
  logic [ID_W-1:0]   win_id_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic              unused_rsig;

  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;

  // R payload is a straight pass-through; only resp_valid qualifies it
  assign resp_data = DATA_W'(rdata);
  assign resp_last = rlast;
  assign resp_err  = rresp[1];

  // Only one burst is ever outstanding, so rid and rresp[0] carry no information
  assign unused_rsig = ^{rid, rresp[0]};

  // Winner: the sole requester, or on a tie the port that did not go last
  always_comb begin
    winner_c = req_valid[1];
    if (req_valid == 2'b11) begin
      winner_c = ~last_grant_q;
    end
    win_addr_c = winner_c ? req_addr1 : req_addr0;
    win_len_c  = winner_c ? req_len1  : req_len0;
    win_id_c   = winner_c ? ID_D      : ID_I;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_c         = 1'b0;
    burst_done_c   = 1'b0;
    req_ready      = 2'b00;
    resp_valid     = 2'b00;
    owner_onehot_c = owner_q ? 2'b10 : 2'b01;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          load_c  = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (arvalid && arready) begin
          req_ready = owner_onehot_c;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (rvalid) begin
          resp_valid = owner_onehot_c;
        end
        // Error beats do not end the burst; only rlast does
        if (rvalid && rlast) begin
          burst_done_c = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake strobes follow the next state so they are clean flop outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid <= 1'b0;
      rready  <= 1'b0;
    end else begin
      arvalid <= (state_d == ADDR);
      rready  <= (state_d == DATA);
    end
  end

  // AR fields are captured at grant and held until the handshake completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      araddr       <= '0;
      arlen        <= '0;
      arid         <= '0;
    end else begin
      if (load_c) begin
        owner_q <= winner_c;
        araddr  <= win_addr_c;
        arlen   <= win_len_c;
        arid    <= win_id_c;
      end
      if (burst_done_c) begin
        last_grant_q <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: a randomized AXI slave plus a
// transaction-level model of grant order and expected AR/R behaviour.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_addr0, req_addr1;
  logic [3:0]  req_len0, req_len1;
  logic [1:0]  req_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_valid;
  logic        resp_last, resp_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  // Model state: which port won the most recent completed burst
  bit m_last;

  // Observations gathered by the slave for one transaction
  int          obs_ar_wait, obs_arv_cycles, obs_ar_bad, obs_rr_ok, obs_rr_bad;
  int          obs_beats, obs_beat_bad, obs_last_cnt, obs_err_cnt, obs_leak;
  logic [3:0]  obs_arid, obs_arlen;
  logic [31:0] obs_araddr;
  logic [2:0]  obs_arsize;
  logic [1:0]  obs_arburst;
  logic        obs_ab_arv, obs_ab_rready;
  logic [1:0]  obs_ab_rv;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_len0(req_len0), .req_len1(req_len1), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_last(resp_last), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Rotating priority: search begins at the port after the last winner
  function automatic int pick(input logic [1:0] r, input bit last);
    int p;
    for (int k = 1; k <= 2; k++) begin
      p = (int'(last) + k) % 2;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  // AXI slave for one transaction owned by `port`; records what the DUT did
  task automatic serve(input int port, input logic [3:0] len, input int ar_delay,
                       input int gap_max, input int err_mode, input bit early_rv,
                       input bit keep, input int abort_beat, input logic [1:0] late_mask,
                       input int late_beat);
    int cyc_n, arv_seen, beat, gap;
    bit phase, done, rv, need;
    logic [31:0] bdata;
    logic [1:0]  bresp, onehot;
    onehot = (port == 1) ? 2'b10 : 2'b01;
    obs_ar_wait = -1; obs_arv_cycles = 0; obs_ar_bad = 0; obs_rr_ok = 0; obs_rr_bad = 0;
    obs_beats = 0; obs_beat_bad = 0; obs_last_cnt = 0; obs_err_cnt = 0; obs_leak = 0;
    obs_ab_arv = 1'bx; obs_ab_rready = 1'bx; obs_ab_rv = 2'bxx;
    need = 1; phase = 0; done = 0; cyc_n = 0; arv_seen = 0; beat = 0; gap = 0;
    bdata = '0; bresp = '0;
    while (!done && cyc_n < 400) begin
      if (need) begin
        bdata = $urandom;
        bresp = (err_mode == 0) ? 2'b00 : (err_mode == 2) ? 2'b10 : 2'($urandom_range(0, 3));
        gap   = (early_rv && beat == 0) ? 0 : int'($urandom_range(0, gap_max));
        need  = 0;
      end
      arready = !phase && (arv_seen >= ar_delay);
      rv      = phase ? (gap == 0) : early_rv;
      rvalid  = rv;
      rdata   = rv ? bdata : $urandom;
      rresp   = bresp;
      rlast   = rv && (beat == int'(len));
      rid     = 4'($urandom);
      if (phase && !keep) req_valid[port] = 1'b0;
      if (phase && beat == late_beat) req_valid = req_valid | late_mask;
      if (phase && rv && beat == abort_beat) rst = 1'b1;
      @(negedge clk);
      if (!phase) begin
        if (rready !== 1'b0 || resp_valid !== 2'b00) obs_leak++;
        if (arvalid === 1'b1) begin
          if (arv_seen == 0) begin
            obs_ar_wait = cyc_n; obs_arid = arid; obs_araddr = araddr; obs_arlen = arlen;
            obs_arsize = arsize; obs_arburst = arburst;
          end else if (araddr !== obs_araddr || arlen !== obs_arlen || arid !== obs_arid) begin
            obs_ar_bad++;
          end
          arv_seen++;
          obs_arv_cycles++;
          if (arready) begin
            if (req_ready === onehot) obs_rr_ok++; else obs_rr_bad++;
            phase = 1;
          end else if (req_ready !== 2'b00) obs_rr_bad++;
        end else if (req_ready !== 2'b00) obs_rr_bad++;
      end else begin
        if (req_ready !== 2'b00) obs_rr_bad++;
        if (rv && beat == abort_beat) begin
          obs_ab_arv = arvalid; obs_ab_rready = rready; obs_ab_rv = resp_valid;
          done = 1;
        end else begin
          if (rready !== 1'b1 || arvalid !== 1'b0) obs_beat_bad++;
          if (rv) begin
            if (resp_valid !== onehot || resp_data !== bdata || resp_last !== rlast ||
                resp_err !== bresp[1]) obs_beat_bad++;
            if (resp_last === 1'b1) obs_last_cnt++;
            if (resp_err === 1'b1) obs_err_cnt++;
            obs_beats++;
            if (rlast) done = 1;
            beat++;
            need = 1;
          end else begin
            if (resp_valid !== 2'b00) obs_beat_bad++;
            gap--;
          end
        end
      end
      cyc_n++;
      cyc();
    end
    rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = 2'b00; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; arready = 1'b1; rvalid = 1'b1; rlast = 1'b1;
    rresp = 2'b10; rdata = 32'hDEAD_BEEF; rid = 4'd0;
    req_addr0 = 32'h1234_5670; req_addr1 = 32'h89AB_CDE0; req_len0 = 4'd3; req_len1 = 4'd5;
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b expected 0", rready); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
    checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr: got %h expected 0", araddr); end
    checks++; if (arlen !== 4'h0) begin errors++; $display("FAIL reset_arlen: got %0d expected 0", arlen); end
    checks++; if (arid !== 4'h0) begin errors++; $display("FAIL reset_arid: got %0d expected 0", arid); end
    checks++; if (arsize !== 3'b010) begin errors++; $display("FAIL const_arsize: got %b expected 010", arsize); end
    checks++; if (arburst !== 2'b01) begin errors++; $display("FAIL const_arburst: got %b expected 01", arburst); end
    apply_reset();
  endtask

  task automatic test_port0();
    int p;
    req_addr0 = 32'h1FC0_0000; req_len0 = 4'd7; req_valid = 2'b01;
    p = pick(req_valid, m_last);
    serve(p, 4'd7, 3, 1, 0, 1'b0, 1'b0, -1, 2'b00, -1);
    m_last = p[0];
    checks++; if (obs_ar_wait !== 1) begin errors++; $display("FAIL p0_ar_latency: got %0d expected 1", obs_ar_wait); end
    checks++; if (obs_arid !== 4'd0) begin errors++; $display("FAIL p0_arid: got %0d expected 0", obs_arid); end
    checks++; if (obs_araddr !== 32'h1FC0_0000) begin errors++; $display("FAIL p0_araddr: got %h expected 1fc00000", obs_araddr); end
    checks++; if (obs_arlen !== 4'd7) begin errors++; $display("FAIL p0_arlen: got %0d expected 7", obs_arlen); end
    checks++; if (obs_arsize !== 3'd2 || obs_arburst !== 2'd1) begin errors++; $display("FAIL p0_size_burst: got %0d/%0d expected 2/1", obs_arsize, obs_arburst); end
    checks++; if (obs_arv_cycles !== 4) begin errors++; $display("FAIL p0_arvalid_hold: got %0d expected 4", obs_arv_cycles); end
    checks++; if (obs_ar_bad !== 0) begin errors++; $display("FAIL p0_ar_stable: got %0d unstable cycles expected 0", obs_ar_bad); end
    checks++; if (obs_rr_ok !== 1 || obs_rr_bad !== 0) begin errors++; $display("FAIL p0_req_ready: got %0d good %0d bad expected 1/0", obs_rr_ok, obs_rr_bad); end
    checks++; if (obs_beats !== 8) begin errors++; $display("FAIL p0_beats: got %0d expected 8", obs_beats); end
    checks++; if (obs_beat_bad !== 0) begin errors++; $display("FAIL p0_beat_content: got %0d bad beats expected 0", obs_beat_bad); end
    checks++; if (obs_last_cnt !== 1) begin errors++; $display("FAIL p0_last: got %0d expected 1", obs_last_cnt); end
    @(negedge clk);
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL p0_rready_drop: got %b expected 0", rready); end
    cyc();
  endtask

  task automatic test_tie_alternation();
    int p;
    logic [3:0] exp_id;
    apply_reset();
    req_addr0 = 32'h0000_1000; req_addr1 = 32'h0000_2000; req_len0 = 4'd1; req_len1 = 4'd2;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      p = pick(req_valid, m_last);
      exp_id = 4'(p);
      serve(p, (p == 1) ? req_len1 : req_len0, int'($urandom_range(0, 2)), 1, 0, 1'b0, 1'b1, -1, 2'b00, -1);
      m_last = p[0];
      checks++; if (obs_arid !== exp_id) begin errors++; $display("FAIL tie_grant%0d_arid: got %0d expected %0d", i, obs_arid, exp_id); end
      checks++; if (obs_ar_wait !== 1) begin errors++; $display("FAIL tie_grant%0d_latency: got %0d expected 1", i, obs_ar_wait); end
      checks++; if (obs_beat_bad !== 0 || obs_beats !== ((p == 1) ? 3 : 2)) begin errors++; $display("FAIL tie_grant%0d_beats: got %0d (%0d bad) expected %0d", i, obs_beats, obs_beat_bad, (p == 1) ? 3 : 2); end
    end
    req_valid = 2'b00;
    cyc();
    @(negedge clk);
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL tie_idle_arvalid: got %b expected 0", arvalid); end
    cyc();
  endtask

  task automatic test_err_beat();
    int p;
    req_addr1 = 32'hBFAF_8000; req_len1 = 4'd0; req_valid = 2'b10;
    p = pick(req_valid, m_last);
    serve(p, 4'd0, 1, 0, 2, 1'b0, 1'b0, -1, 2'b00, -1);
    m_last = p[0];
    checks++; if (obs_arid !== 4'd1 || obs_araddr !== 32'hBFAF_8000) begin errors++; $display("FAIL err_ar: got id %0d addr %h expected 1 bfaf8000", obs_arid, obs_araddr); end
    checks++; if (obs_err_cnt !== 1) begin errors++; $display("FAIL err_resp_err: got %0d expected 1", obs_err_cnt); end
    checks++; if (obs_last_cnt !== 1 || obs_beats !== 1) begin errors++; $display("FAIL err_last: got last %0d beats %0d expected 1/1", obs_last_cnt, obs_beats); end
    checks++; if (obs_beat_bad !== 0) begin errors++; $display("FAIL err_beat_content: got %0d bad expected 0", obs_beat_bad); end
    @(negedge clk);
    checks++; if (rready !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL err_idle: got rready %b arvalid %b expected 0 0", rready, arvalid); end
    cyc();
  endtask

  task automatic test_early_rvalid();
    int p;
    req_addr0 = 32'h0040_0100; req_len0 = 4'd3; req_valid = 2'b01;
    p = pick(req_valid, m_last);
    serve(p, 4'd3, 2, 1, 1, 1'b1, 1'b0, -1, 2'b00, -1);
    m_last = p[0];
    checks++; if (obs_leak !== 0) begin errors++; $display("FAIL early_leak: got %0d leaking cycles expected 0", obs_leak); end
    checks++; if (obs_beats !== 4) begin errors++; $display("FAIL early_beats: got %0d expected 4", obs_beats); end
    checks++; if (obs_beat_bad !== 0) begin errors++; $display("FAIL early_beat_content: got %0d bad expected 0", obs_beat_bad); end
  endtask

  task automatic test_reset_mid_burst();
    int p;
    req_addr0 = 32'h0000_8000; req_len0 = 4'd7; req_valid = 2'b01;
    p = pick(req_valid, m_last);
    serve(p, 4'd7, 1, 0, 0, 1'b0, 1'b0, 3, 2'b00, -1);
    checks++; if (obs_ab_arv !== 1'b0 || obs_ab_rready !== 1'b0) begin errors++; $display("FAIL abort_strobes: got arvalid %b rready %b expected 0 0", obs_ab_arv, obs_ab_rready); end
    checks++; if (obs_ab_rv !== 2'b00) begin errors++; $display("FAIL abort_resp_valid: got %b expected 00", obs_ab_rv); end
    checks++; if (obs_beats !== 3) begin errors++; $display("FAIL abort_beats_before: got %0d expected 3", obs_beats); end
    cyc();
    rst = 1'b0;
    m_last = 1'b1;
    req_addr0 = 32'h0000_9000; req_len0 = 4'd2; req_valid = 2'b01;
    p = pick(req_valid, m_last);
    serve(p, 4'd2, 0, 1, 1, 1'b0, 1'b0, -1, 2'b00, -1);
    m_last = p[0];
    checks++; if (obs_arid !== 4'd0 || obs_araddr !== 32'h0000_9000) begin errors++; $display("FAIL post_reset_ar: got id %0d addr %h expected 0 9000", obs_arid, obs_araddr); end
    checks++; if (obs_ar_wait !== 1 || obs_beats !== 3 || obs_beat_bad !== 0) begin errors++; $display("FAIL post_reset_burst: got wait %0d beats %0d bad %0d expected 1 3 0", obs_ar_wait, obs_beats, obs_beat_bad); end
  endtask

  task automatic test_late_request();
    int p;
    req_addr0 = 32'h0010_0000; req_len0 = 4'd5;
    req_addr1 = 32'h0020_0040; req_len1 = 4'd2;
    req_valid = 2'b01;
    p = pick(req_valid, m_last);
    serve(p, 4'd5, 1, 1, 0, 1'b0, 1'b0, -1, 2'b10, 2);
    m_last = p[0];
    checks++; if (obs_beat_bad !== 0 || obs_rr_bad !== 0) begin errors++; $display("FAIL late_no_early_grant: got %0d bad beats %0d bad req_ready expected 0 0", obs_beat_bad, obs_rr_bad); end
    p = pick(req_valid, m_last);
    serve(p, 4'd2, 1, 1, 0, 1'b0, 1'b0, -1, 2'b00, -1);
    m_last = p[0];
    checks++; if (obs_ar_wait !== 1) begin errors++; $display("FAIL late_ar_latency: got %0d expected 1", obs_ar_wait); end
    checks++; if (obs_arid !== 4'd1 || obs_araddr !== 32'h0020_0040) begin errors++; $display("FAIL late_ar_fields: got id %0d addr %h expected 1 200040", obs_arid, obs_araddr); end
    checks++; if (obs_beats !== 3 || obs_beat_bad !== 0) begin errors++; $display("FAIL late_beats: got %0d (%0d bad) expected 3", obs_beats, obs_beat_bad); end
  endtask

  task automatic test_random();
    int p, d, n;
    logic [3:0]  elen;
    logic [31:0] eaddr;
    for (int it = 0; it < 16; it++) begin
      req_addr0 = $urandom & 32'hFFFF_FFFC; req_addr1 = $urandom & 32'hFFFF_FFFC;
      req_len0 = 4'($urandom_range(0, 15)); req_len1 = 4'($urandom_range(0, 15));
      req_valid = 2'($urandom_range(1, 3));
      n = 0;
      while (req_valid != 2'b00 && n < 2) begin
        p = pick(req_valid, m_last);
        elen = (p == 1) ? req_len1 : req_len0;
        eaddr = (p == 1) ? req_addr1 : req_addr0;
        d = int'($urandom_range(0, 3));
        serve(p, elen, d, 2, 1, 1'b0, 1'b0, -1, 2'b00, -1);
        m_last = p[0];
        n++;
        checks++; if (obs_arid !== 4'(p) || obs_araddr !== eaddr || obs_arlen !== elen) begin errors++; $display("FAIL rnd%0d_ar: got id %0d addr %h len %0d expected %0d %h %0d", it, obs_arid, obs_araddr, obs_arlen, p, eaddr, elen); end
        checks++; if (obs_ar_wait !== 1 || obs_arv_cycles !== d + 1 || obs_ar_bad !== 0) begin errors++; $display("FAIL rnd%0d_ar_timing: got wait %0d hold %0d unstable %0d expected 1 %0d 0", it, obs_ar_wait, obs_arv_cycles, obs_ar_bad, d + 1); end
        checks++; if (obs_rr_ok !== 1 || obs_rr_bad !== 0) begin errors++; $display("FAIL rnd%0d_req_ready: got %0d/%0d expected 1/0", it, obs_rr_ok, obs_rr_bad); end
        checks++; if (obs_beats !== int'(elen) + 1 || obs_beat_bad !== 0 || obs_last_cnt !== 1) begin errors++; $display("FAIL rnd%0d_beats: got %0d bad %0d last %0d expected %0d 0 1", it, obs_beats, obs_beat_bad, obs_last_cnt, int'(elen) + 1); end
      end
    end
  endtask

  initial begin
    req_valid = 2'b00; req_addr0 = '0; req_addr1 = '0; req_len0 = '0; req_len1 = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    rst = 1'b1;
    m_last = 1'b1;
    test_reset();
    test_port0();
    test_tie_alternation();
    test_err_beat();
    test_early_rvalid();
    test_reset_mid_burst();
    test_late_request();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
